// File: rtl/mw_add_pkg.sv
// rtl/mw_add_pkg.sv - shared constants and state encoding for the multi-word adder sequencer
package mw_add_pkg;

    // Default slice width and chunk count
    localparam int MW_WIDTH = 8;
    localparam int MW_WORDS = 4;

    // Sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        MW_IDLE = 2'd0,
        MW_RUN  = 2'd1,
        MW_DONE = 2'd2
    } mw_state_e;

    // Plain constants for the state register, kept for legacy tooling
    localparam logic [1:0] ST_IDLE = MW_IDLE;
    localparam logic [1:0] ST_RUN  = MW_RUN;
    localparam logic [1:0] ST_DONE = MW_DONE;

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational WIDTH-bit ripple-carry adder slice with carry in/out
module add_slice #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic c;

    // Bit-serial carry chain, LSB first
    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/mw_add_sequencer.sv
// rtl/mw_add_sequencer.sv - multi-precision adder sequencer reusing one slice; optional subtract via MW_ADD_SUB_EN
module mw_add_sequencer
    import mw_add_pkg::*;
#(
    parameter int WIDTH = MW_WIDTH,
    parameter int WORDS = MW_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WORDS*WIDTH-1:0] a_in,
    input  logic [WORDS*WIDTH-1:0] b_in,
`ifdef MW_ADD_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [WORDS*WIDTH-1:0] sum_out,
    output logic                   carry_out
);

    localparam int OPW  = WORDS * WIDTH;
    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    logic [1:0]       state;
    logic [IDXW-1:0]  idx;
    logic             carry_q;
    logic [OPW-1:0]   a_q;
    logic [OPW-1:0]   b_q;

    logic [WIDTH-1:0] slice_a;
    logic [WIDTH-1:0] slice_b;
    logic [WIDTH-1:0] slice_sum;
    logic             slice_cout;
    logic             invert_b;
    logic             carry_init;

`ifdef MW_ADD_SUB_EN
    logic sub_q;

    // Subtraction is A + ~B + 1: invert B chunks and seed the carry with 1
    assign invert_b   = sub_q;
    assign carry_init = sub;
`else
    assign invert_b   = 1'b0;
    assign carry_init = 1'b0;
`endif

    assign slice_a = a_q[idx*WIDTH +: WIDTH];
    assign slice_b = b_q[idx*WIDTH +: WIDTH] ^ {WIDTH{invert_b}};

    add_slice #(
        .WIDTH (WIDTH)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // Sequencer: capture on start, one chunk per RUN cycle, single DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
`ifdef MW_ADD_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        idx     <= '0;
                        carry_q <= carry_init;
`ifdef MW_ADD_SUB_EN
                        sub_q   <= sub;
`endif
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_out[idx*WIDTH +: WIDTH] <= slice_sum;
                    carry_q <= slice_cout;
                    if (idx == LAST_IDX) begin
                        // idx parks at the last chunk; it is cleared on the next capture
                        carry_out <= slice_cout;
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mw_add_sequencer.sv
// tb/tb_mw_add_sequencer.sv - scoreboard testbench for mw_add_sequencer
module tb_mw_add_sequencer;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int OPW   = WIDTH * WORDS;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [OPW-1:0] a_in;
    logic [OPW-1:0] b_in;
    logic           sub;
    logic           busy;
    logic           done;
    logic [OPW-1:0] sum_out;
    logic           carry_out;

    int checks = 0;
    int errors = 0;

    logic [OPW:0] sb[$];

    mw_add_sequencer #(
        .WIDTH (WIDTH),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
`ifdef MW_ADD_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                            input logic s, input bit push);
        logic [OPW:0] exp;
        @(posedge clk);
        #1;
        a_in  = a;
        b_in  = b;
        sub   = s;
        start = 1'b1;
        if (s) begin
            exp = {(a >= b), a - b};
        end else begin
            exp = {1'b0, a} + {1'b0, b};
        end
        if (push) sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called in the cycle after acceptance; optionally pokes start at poke_cycle and in the DONE cycle
    task automatic wait_done(input string tag, input int poke_cycle);
        int           k;
        int           busy_cnt;
        int           done_cycle;
        bit           seen;
        logic [OPW:0] exp;
        k          = 0;
        busy_cnt   = 0;
        done_cycle = 0;
        seen       = 1'b0;
        while (!seen && k < 20) begin
            k++;
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                seen       = 1'b1;
                done_cycle = k;
            end
            if (poke_cycle > 0 && (k == poke_cycle || done)) begin
                start = 1'b1;
                a_in  = '1;
                b_in  = '1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_latency"}, 64'(done_cycle), 64'(WORDS + 1));
            check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(WORDS + 1));
            check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check({tag, "_sum"}, 64'(sum_out), 64'(exp[OPW-1:0]));
                check({tag, "_carry"}, 64'(carry_out), 64'(exp[OPW]));
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        sub   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum_out), 64'd0);
        check("rst_carry", 64'(carry_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry out of chunk 0 into chunk 1
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
        wait_done("t1", 0);
        check_idle("t1");

        // Carry ripples through all four chunks into carry_out
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        wait_done("t2", 0);
        check_idle("t2");

        // Start during RUN and during DONE must be ignored
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        wait_done("t3", 2);
        check_idle("t3");
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t3_no_extra_done", 64'(ndone), 64'd0);
        check("t3_sum_held", 64'(sum_out), 64'h2345_6789);
        check("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Back-to-back: restart in the cycle right after done
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_done("t5a", 0);
        start_op(32'hFFFF_0000, 32'h0002_0000, 1'b0, 1'b1);
        check("t5_prev_held", 64'(sum_out), 64'hFFFF_FFFE);
        check("t5_prev_carry_held", 64'(carry_out), 64'd1);
        wait_done("t5b", 0);
        check_idle("t5b");

        // Reset mid-RUN aborts the operation
        start_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_done", 64'(done), 64'd0);
        check("t4_sum", 64'(sum_out), 64'd0);
        check("t4_carry", 64'(carry_out), 64'd0);
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        check("t4_no_done_in_reset", 64'(ndone), 64'd0);
        start_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
        wait_done("t4b", 0);
        check_idle("t4b");

`ifdef MW_ADD_SUB_EN
        // Subtract with and without borrow
        start_op(32'd5, 32'd7, 1'b1, 1'b1);
        wait_done("s1", 0);
        check("s1_sum_const", 64'(sum_out), 64'hFFFF_FFFE);
        check("s1_carry_const", 64'(carry_out), 64'd0);
        start_op(32'd7, 32'd5, 1'b1, 1'b1);
        wait_done("s2", 0);
        check("s2_sum_const", 64'(sum_out), 64'h0000_0002);
        check("s2_carry_const", 64'(carry_out), 64'd1);
        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
        wait_done("s3", 0);
`endif

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
